// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : CPU-side initiator of the byte-wide memory bus. Serialises word
//            fetches and 1/2/4-byte loads/stores, reassembles read bytes and
//            honours rdy_in and io_buffer_full stalls.
// Revision : 1.0  initial release
// ============================================================================
module mem_ctrl #(
   parameter int RAM_ADDR_WIDTH = 17
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_abort,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_done,
   output logic [31:0] d_rdata
);

   typedef enum logic [2:0] {IDLE, IF_RD, D_RD, D_WR, IO_GAP} state_t;

   state_t      state, nxt_state;
   logic [2:0]  cnt, nxt_cnt;          // bytes issued so far
   logic [2:0]  len, nxt_len;          // bytes in the transfer (1, 2 or 4)
   logic [31:0] base, nxt_base;
   logic [31:0] wdata, nxt_wdata;
   logic        pend, nxt_pend;        // a read byte is due on mem_din this cycle
   logic [1:0]  pidx, nxt_pidx;        // byte lane of the pending read byte
   logic [31:0] rbuf, nxt_rbuf;
   logic [31:0] nxt_mem_a, nxt_if_data, nxt_d_rdata;
   logic [7:0]  nxt_mem_dout;
   logic        nxt_mem_wr, nxt_if_done, nxt_d_done;

   logic [2:0]  cnt_inc;
   logic [31:0] cur_addr, next_addr, merged;
   logic [7:0]  cur_byte, next_byte;
   logic        last_cap;

   function automatic logic is_io(input logic [31:0] a);
      return a[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] == 2'b11;
   endfunction

   function automatic logic [2:0] size_len(input logic [1:0] s);
      return (s == 2'd0) ? 3'd1 : (s == 2'd1) ? 3'd2 : 3'd4;
   endfunction

   assign cnt_inc   = cnt + 3'd1;
   assign cur_addr  = base + {29'd0, cnt};
   assign next_addr = cur_addr + 32'd1;
   assign cur_byte  = wdata[{cnt[1:0], 3'b000} +: 8];
   assign next_byte = wdata[{cnt_inc[1:0], 3'b000} +: 8];
   assign last_cap  = pend && ({1'b0, pidx} == (len - 3'd1));

   // Read buffer with the byte currently on mem_din dropped into its lane.
   always_comb begin
      merged = rbuf;
      merged[{pidx, 3'b000} +: 8] = mem_din;
   end

   // Next-state and next-output logic; every bus output is registered.
   always_comb begin
      nxt_state    = state;
      nxt_cnt      = cnt;
      nxt_len      = len;
      nxt_base     = base;
      nxt_wdata    = wdata;
      nxt_pend     = 1'b0;
      nxt_pidx     = pidx;
      nxt_rbuf     = rbuf;
      nxt_mem_a    = mem_a;
      nxt_mem_dout = mem_dout;
      nxt_mem_wr   = mem_wr;
      nxt_if_done  = 1'b0;
      nxt_d_done   = 1'b0;
      nxt_if_data  = if_data;
      nxt_d_rdata  = d_rdata;
      case (state)
         IDLE: begin
            nxt_mem_a  = 32'd0;
            nxt_mem_wr = 1'b0;
            // The requester drops its request during a done cycle, so no accept then.
            if (rdy_in && !if_done && !d_done) begin
               if (d_req) begin
                  nxt_len   = size_len(d_size);
                  nxt_base  = d_addr;
                  nxt_wdata = d_wdata;
                  nxt_cnt   = 3'd0;
                  nxt_rbuf  = 32'd0;
                  if (d_we) begin
                     nxt_state = D_WR;
                     if (!(is_io(d_addr) && io_buffer_full)) begin
                        nxt_mem_a    = d_addr;
                        nxt_mem_dout = d_wdata[7:0];
                        nxt_mem_wr   = 1'b1;
                     end
                  end else begin
                     nxt_state = D_RD;
                     nxt_mem_a = d_addr;
                  end
               end else if (if_req && !if_abort) begin
                  nxt_state = IF_RD;
                  nxt_len   = 3'd4;
                  nxt_base  = if_addr;
                  nxt_cnt   = 3'd0;
                  nxt_rbuf  = 32'd0;
                  nxt_mem_a = if_addr;
               end
            end
         end
         IF_RD, D_RD: begin
            if (state == IF_RD && if_abort) begin
               nxt_state = IDLE;
               nxt_mem_a = 32'd0;
            end else begin
               // Capture is unconditional: the RAM sampled the address at the issuing edge.
               if (pend) nxt_rbuf = merged;
               if (last_cap) begin
                  nxt_state = IDLE;
                  nxt_mem_a = 32'd0;
                  if (state == IF_RD) begin
                     nxt_if_done = 1'b1;
                     nxt_if_data = merged;
                  end else begin
                     nxt_d_done  = 1'b1;
                     nxt_d_rdata = merged;
                  end
               end else if (cnt < len && rdy_in) begin
                  nxt_pend  = 1'b1;
                  nxt_pidx  = cnt[1:0];
                  nxt_cnt   = cnt_inc;
                  nxt_mem_a = (cnt_inc < len) ? next_addr : 32'd0;
               end
            end
         end
         D_WR: begin
            if (mem_wr) begin
               if (rdy_in) begin
                  nxt_cnt    = cnt_inc;
                  nxt_mem_wr = 1'b0;
                  nxt_mem_a  = 32'd0;
                  if (cnt_inc == len) nxt_d_done = 1'b1;
                  if (is_io(cur_addr)) begin
                     // The FIFO full flag lags by a cycle, so idle the bus once.
                     nxt_state = IO_GAP;
                  end else if (cnt_inc == len) begin
                     nxt_state = IDLE;
                  end else if (!(is_io(next_addr) && io_buffer_full)) begin
                     nxt_mem_a    = next_addr;
                     nxt_mem_dout = next_byte;
                     nxt_mem_wr   = 1'b1;
                  end
               end
            end else if (!io_buffer_full) begin
               nxt_mem_a    = cur_addr;
               nxt_mem_dout = cur_byte;
               nxt_mem_wr   = 1'b1;
            end
         end
         IO_GAP: begin
            if (cnt == len) begin
               nxt_state = IDLE;
            end else begin
               nxt_state = D_WR;
               if (!(is_io(cur_addr) && io_buffer_full)) begin
                  nxt_mem_a    = cur_addr;
                  nxt_mem_dout = cur_byte;
                  nxt_mem_wr   = 1'b1;
               end
            end
         end
         default: begin
            nxt_state  = IDLE;
            nxt_mem_a  = 32'd0;
            nxt_mem_wr = 1'b0;
         end
      endcase
   end

   // State and output registers; reset releases the bus immediately.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state    <= IDLE;
         cnt      <= 3'd0;
         len      <= 3'd0;
         base     <= 32'd0;
         wdata    <= 32'd0;
         pend     <= 1'b0;
         pidx     <= 2'd0;
         rbuf     <= 32'd0;
         mem_a    <= 32'd0;
         mem_dout <= 8'd0;
         mem_wr   <= 1'b0;
         if_done  <= 1'b0;
         d_done   <= 1'b0;
         if_data  <= 32'd0;
         d_rdata  <= 32'd0;
      end else begin
         state    <= nxt_state;
         cnt      <= nxt_cnt;
         len      <= nxt_len;
         base     <= nxt_base;
         wdata    <= nxt_wdata;
         pend     <= nxt_pend;
         pidx     <= nxt_pidx;
         rbuf     <= nxt_rbuf;
         mem_a    <= nxt_mem_a;
         mem_dout <= nxt_mem_dout;
         mem_wr   <= nxt_mem_wr;
         if_done  <= nxt_if_done;
         d_done   <= nxt_d_done;
         if_data  <= nxt_if_data;
         d_rdata  <= nxt_d_rdata;
      end
   end

endmodule
`default_nettype wire
